// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory interface driving a word SRAM with registered controls.
// Stores are posted; loads stall the pipeline until aligned read data is captured.
module dmem_if #(
    parameter int ADDR_W   = 14,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mreq,
    input  logic              write,
    input  logic [1:0]        byte_size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall_mem,
    output logic              misalign,
    output logic [31:0]       misalign_addr,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int CW = $clog2(READ_LAT + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0] off_q;
    logic half, word, aligned, acc, bad, capture;
    logic [3:0] be_c;
    logic [31:0] wd_c;
    always_comb begin
        half      = byte_size == 2'b01;
        word      = byte_size[1];
        aligned   = word ? addr[1:0] == 2'b00 : half ? ~addr[0] : 1'b1;
        acc       = state_q == IDLE && mreq && aligned;
        bad       = state_q == IDLE && mreq && !aligned;
        capture   = state_q == WAIT && cnt_q == '0;
        be_c      = word ? 4'b1111 : half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        wd_c      = word ? wdata : half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        state_d   = state_q == IDLE  ? (acc && !write ? ISSUE : IDLE) :
                    state_q == ISSUE ? WAIT :
                    state_q == WAIT  ? (capture ? DONE : WAIT) : IDLE;
        stall_mem = !rst && (state_q == ISSUE || state_q == WAIT || (acc && !write));
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce       <= 1'b0;
            sram_we       <= 1'b0;
            sram_be       <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            rdata         <= '0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            cnt_q         <= '0;
            off_q         <= '0;
        end else begin
            sram_ce  <= acc;
            sram_we  <= acc && write;
            misalign <= bad;
            if (bad) misalign_addr <= addr;
            if (acc) begin
                sram_be   <= write ? be_c : 4'b1111;
                sram_addr <= addr[ADDR_W+1:2];
                if (write) sram_wdata <= wd_c;
                else off_q <= addr[1:0];
            end
            // counter reaching zero in WAIT marks the data-valid cycle
            if (state_q == ISSUE) cnt_q <= CW'(READ_LAT - 1);
            else if (state_q == WAIT && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            if (capture) rdata <= sram_rdata >> {off_q, 3'b000};
        end
    end
endmodule

// File: tb/tb_dmem_if.sv
// tb_dmem_if: directed checks of dmem_if with READ_LAT=1 (backed by an SRAM model)
// and READ_LAT=3 (fixed read word), each held in reset while the other is exercised.
module tb_dmem_if;
    logic clk = 1'b0;
    logic rst1, rst3, mreq, write, sel;
    logic [1:0] byte_size;
    logic [31:0] addr, wdata;
    logic [31:0] rd1, rd3, maddr1, maddr3, wd1, wd3, srd1;
    logic st1, st3, mis1, mis3, ce1, ce3, we1, we3;
    logic [3:0] be1, be3;
    logic [13:0] sa1, sa3;
    logic [31:0] mem [0:255];
    logic [31:0] rd, maddr, wd;
    logic stall, mis, ce, we;
    logic [3:0] be;
    logic [13:0] sa;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(14), .READ_LAT(1)) u1 (
        .clk(clk), .rst(rst1), .mreq(mreq), .write(write), .byte_size(byte_size),
        .addr(addr), .wdata(wdata), .rdata(rd1), .stall_mem(st1), .misalign(mis1),
        .misalign_addr(maddr1), .sram_ce(ce1), .sram_we(we1), .sram_be(be1),
        .sram_addr(sa1), .sram_wdata(wd1), .sram_rdata(srd1));

    dmem_if #(.ADDR_W(14), .READ_LAT(3)) u3 (
        .clk(clk), .rst(rst3), .mreq(mreq), .write(write), .byte_size(byte_size),
        .addr(addr), .wdata(wdata), .rdata(rd3), .stall_mem(st3), .misalign(mis3),
        .misalign_addr(maddr3), .sram_ce(ce3), .sram_we(we3), .sram_be(be3),
        .sram_addr(sa3), .sram_wdata(wd3), .sram_rdata(32'hCAFEF00D));

    always @(posedge clk) begin
        if (ce1) begin
            if (we1) begin
                for (int b = 0; b < 4; b++)
                    if (be1[b]) mem[sa1[7:0]][8*b +: 8] <= wd1[8*b +: 8];
            end else srd1 <= mem[sa1[7:0]];
        end
    end

    always_comb begin
        stall = sel ? st3 : st1;
        mis   = sel ? mis3 : mis1;
        ce    = sel ? ce3 : ce1;
        we    = sel ? we3 : we1;
        be    = sel ? be3 : be1;
        sa    = sel ? sa3 : sa1;
        rd    = sel ? rd3 : rd1;
        wd    = sel ? wd3 : wd1;
        maddr = sel ? maddr3 : maddr1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
        mreq = 1'b1; write = 1'b1; addr = a; byte_size = sz; wdata = d;
        #1;
        chk("store_no_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("store_ce_we", {30'd0, ce, we}, 32'd3);
        chk("store_be", {28'd0, be}, {28'd0, exp_be});
        chk("store_addr", {18'd0, sa}, {18'd0, a[15:2]});
        chk("store_wdata", wd, exp_wd);
        mreq = 1'b0;
        tick();
        chk("store_ce_drop", {30'd0, ce, we}, 32'd0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input int exp_n,
                        input logic [31:0] exp_rd);
        int n;
        logic [5:0] ctl;
        n = 0;
        ctl = '0;
        mreq = 1'b1; write = 1'b0; addr = a; byte_size = sz;
        #1;
        while (stall && n < 20) begin
            n++;
            tick();
            if (n == 1) ctl = {ce, we, be};
        end
        chk("load_issue_ctl", {26'd0, ctl}, 32'h2F);
        chk("load_stall_cycles", n, exp_n);
        chk("load_rdata", rd, exp_rd);
        mreq = 1'b0;
        tick();
        chk("load_ce_idle", {31'd0, ce}, 32'd0);
    endtask

    task automatic misal(input logic [31:0] a, input logic [1:0] sz, input logic wr);
        mreq = 1'b1; write = wr; addr = a; byte_size = sz;
        #1;
        chk("mis_no_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, mis}, 32'd1);
        chk("mis_addr", maddr, a);
        chk("mis_no_ce", {31'd0, ce}, 32'd0);
        mreq = 1'b0;
        tick();
        chk("mis_pulse_end", {30'd0, mis, ce}, 32'd0);
    endtask

    initial begin
        logic ce_seen, st_seen;
        sel = 1'b0; rst1 = 1'b1; rst3 = 1'b1;
        mreq = 1'b1; write = 1'b0; byte_size = 2'b10; addr = '0; wdata = '0;
        #1;
        chk("stall_in_reset", {31'd0, stall}, 32'd0);
        tick();
        tick();
        rst1 = 1'b0; mreq = 1'b0;
        #1;
        chk("rst_ctl", {26'd0, ce, we, be}, 32'd0);
        chk("rst_addr_wdata", {18'd0, sa} | wd, 32'd0);
        chk("rst_rdata", rd, 32'd0);
        chk("rst_misalign", {31'd0, mis} | maddr, 32'd0);
        ce_seen = 1'b0; st_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            ce_seen |= ce;
            st_seen |= stall;
        end
        chk("idle_quiet", {30'd0, ce_seen, st_seen}, 32'd0);
        store(32'h100, 2'b10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        load(32'h100, 2'b10, 3, 32'hDEADBEEF);
        store(32'h103, 2'b00, 32'h123456A5, 4'b1000, 32'hA5A5A5A5);
        load(32'h103, 2'b00, 3, 32'h000000A5);
        store(32'h102, 2'b01, 32'hFFFFBEEF, 4'b1100, 32'hBEEFBEEF);
        load(32'h100, 2'b11, 3, 32'hBEEFBEEF);
        store(32'h100, 2'b10, 32'h1234ABCD, 4'b1111, 32'h1234ABCD);
        load(32'h102, 2'b01, 3, 32'h00001234);
        load(32'h101, 2'b00, 3, 32'h001234AB);
        store(32'h201, 2'b00, 32'h0000003C, 4'b0010, 32'h3C3C3C3C);
        misal(32'h102, 2'b10, 1'b0);
        misal(32'h105, 2'b01, 1'b1);
        chk("rdata_held", rd, 32'h001234AB);
        rst1 = 1'b1; sel = 1'b1;
        tick();
        rst3 = 1'b0;
        #1;
        load(32'h0, 2'b10, 5, 32'hCAFEF00D);
        mreq = 1'b1; write = 1'b0; addr = 32'h4; byte_size = 2'b10;
        tick();
        tick();
        chk("wait_stall", {31'd0, stall}, 32'd1);
        rst3 = 1'b1;
        #1;
        chk("stall_forced_rst", {31'd0, stall}, 32'd0);
        tick();
        rst3 = 1'b0; mreq = 1'b0;
        #1;
        chk("midrst_idle", {29'd0, stall, ce, we}, 32'd0);
        chk("midrst_rdata", rd, 32'd0);
        load(32'h2, 2'b01, 5, 32'h0000CAFE);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_if.md
# dmem_if

Data-memory interface for the pipelined core's MEM stage. It takes the core's load/store request (address, store data, write flag, byte size, request strobe) and drives a word-organised synchronous SRAM with registered control and byte enables. It aligns load data to bit 0 for the downstream sign-extender. It holds the pipeline with `stall_mem` while a load is outstanding. It sits between the core's ExMem outputs and the data SRAM, and returns load data into the MemWB capture path.

## Interface
- `ADDR_W`, 14: SRAM word-address width; word address = `addr[ADDR_W+1:2]`.
- `READ_LAT`, 1: SRAM read latency in cycles from `sram_ce` (read) to valid `sram_rdata`, ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mreq`  in  1  memory request from MEM stage.
- `write`  in  1  1 = store, 0 = load (qualified by `mreq`).
- `byte_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, LSB-aligned.
- `rdata`  out  32  load data shifted so the addressed byte/half sits at bit 0; upper bits unmasked.
- `stall_mem`  out  1  hold IF..MEM pipeline registers.
- `misalign`  out  1  one-cycle pulse: misaligned access dropped.
- `misalign_addr`  out  32  address of last misaligned access.
- `sram_ce`  out  1  SRAM access strobe (registered).
- `sram_we`  out  1  SRAM write (registered).
- `sram_be`  out  4  byte enables (registered).
- `sram_addr`  out  ADDR_W  word address (registered).
- `sram_wdata`  out  32  lane-replicated store data (registered).
- `sram_rdata`  in  32  SRAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE + `mreq` + aligned store:
  - load SRAM output registers with ce=1, we=1, be, addr, replicated wdata.
  - stay IDLE; no stall. Stores are posted.
- IDLE + `mreq` + aligned load:
  - load output registers with ce=1, we=0, be=1111.
  - latch `addr[1:0]` and size; go ISSUE.
- ISSUE: load wait counter with `READ_LAT-1`. Go WAIT, or go directly to capture if `READ_LAT`=1.
- WAIT: decrement the counter. At the data-valid cycle, capture the aligned `sram_rdata` into `rdata_q` and go DONE.
- DONE: go to IDLE. The held request is not re-accepted because DONE consumes it.
- Alignment rules:
  - half requires `addr[0]`=0.
  - word requires `addr[1:0]`=00.
  - byte is always aligned.
- Misaligned request in IDLE:
  - no SRAM access.
  - `misalign`=1 next cycle; `misalign_addr` updated.
  - no stall.
- Byte enables:
  - byte: one-hot `1<<addr[1:0]`.
  - half: 0011 or 1100 by `addr[1]`.
  - word: 1111.
- Store data: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word unchanged.
- Load alignment: `rdata_q = sram_rdata >> (8*off)`, zero-filled from the top.
- `rdata` = `rdata_q`. It is held until the next load capture.
- `sram_ce`/`sram_we` are high for exactly one cycle per accepted access. At all other times they are 0; addr, be and wdata hold their last values.

## Timing
- Reset values: state IDLE, `sram_ce`=0, `sram_we`=0, `sram_be`=0, `sram_addr`=0, `sram_wdata`=0, `rdata`=0, `misalign`=0, `misalign_addr`=0, counter 0.
- `stall_mem` is forced to 0 while `rst`=1.
- `stall_mem` (combinational) = 1 in these cases:
  - IDLE with `mreq & ~write & aligned`.
  - ISSUE.
  - WAIT.
- `stall_mem` = 0 in DONE, so the pipeline captures `rdata` at the end of DONE.
- Load at cycle T (`READ_LAT`=L):
  - T: stall.
  - T+1: `sram_ce` (ISSUE), stall.
  - T+1+L: capture, stall.
  - T+2+L: DONE, stall=0.
  - Total L+2 stall cycles.
- Store at T: `sram_ce`/`sram_we` at T+1. A store or load accepted at T+1 drives the SRAM at T+2, so program order is kept. Back-to-back stores are issued every cycle.
- Load after store to the same word: the store is written at T+1 and the read is issued at T+2, so the load returns the new data.
- `mreq` is ignored outside IDLE. The core holds its request while stalled.
- `rst` mid-load (any non-IDLE state): return to IDLE next edge and clear `sram_ce`/`sram_we`. The partial read is discarded and `rdata` resets to 0.

## Test plan
- Reset, then idle: all outputs at reset values; `stall_mem`=0; no `sram_ce` for 5 cycles.
- Store word 0xDEADBEEF @0x100, then load word @0x100 (L=1):
  - store: `sram_ce`/`sram_we` one cycle later, be=1111, `sram_addr`=0x40.
  - load: `stall_mem` high exactly 3 cycles; `rdata`=0xDEADBEEF in the release cycle.
- Store byte 0xA5 @0x103:
  - be=1000, `sram_wdata`=0xA5A5A5A5.
  - a following load byte @0x103 with SRAM word 0xA5xxxxxx returns `rdata`=0x000000A5.
- Load half @0x102 from word 0x1234ABCD: `rdata`=0x00001234.
- Misaligned word load @0x102:
  - `misalign` pulse next cycle; `misalign_addr`=0x102.
  - no `sram_ce`; `stall_mem`=0.
- READ_LAT=3, assert `rst` in WAIT:
  - IDLE next cycle; `stall_mem`=0, `rdata`=0.
  - a subsequent load completes normally with 5 stall cycles.
